// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side stream stage.
// Holds the word-count FSM encoding and the transfer counter width.
package fifo_stream_pkg;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } fs_state_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/fifo_stream_out.sv
// Show-ahead FIFO to registered valid/ready stream with a 2-entry skid buffer.
// Optional take counter on o_xfer_cnt when FIFO_STREAM_XFER_CNT_EN is defined.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    input  logic              i_flush,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    input  logic              i_m_ready,
`ifdef FIFO_STREAM_XFER_CNT_EN
    output logic [XFER_CNT_W-1:0] o_xfer_cnt,
`endif
    output logic              o_idle
);

    fs_state_t         r_state;
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_skid;
    logic              w_pop;
    logic              w_take;

    // Pop depends only on registered state and FIFO flags, never on ready.
    assign w_pop = rstn & ~i_fifo_empty & ~i_flush & (r_state != S_TWO);
    assign w_take = o_m_valid & i_m_ready;

    assign o_fifo_rden = w_pop;
    assign o_m_valid   = (r_state != S_EMPTY);
    assign o_idle      = (r_state == S_EMPTY);
    assign o_m_data    = r_out;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_EMPTY;
            r_out   <= '0;
            r_skid  <= '0;
        end else if (i_flush) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_pop) begin
                        r_out   <= i_fifo_rddata;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_take && w_pop) begin
                        r_out <= i_fifo_rddata;
                    end else if (w_take) begin
                        r_state <= S_EMPTY;
                    end else if (w_pop) begin
                        r_skid  <= i_fifo_rddata;
                        r_state <= S_TWO;
                    end
                end
                S_TWO: begin
                    if (w_take) begin
                        r_out   <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

`ifdef FIFO_STREAM_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] r_xfer_cnt;

    // Counts accepted transfers; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_xfer_cnt <= '0;
        end else if (w_take) begin
            r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
        end
    end

    assign o_xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Scoreboard bench for fifo_stream_out with a queue-based show-ahead FIFO model.
// Define FIFO_STREAM_XFER_CNT_EN to also exercise the transfer counter.
module tb_fifo_stream_out;
    import fifo_stream_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_fifo_empty = 1'b1;
    logic [DW-1:0] i_fifo_rddata = '0;
    logic          i_flush = 1'b0;
    logic          i_m_ready = 1'b0;
    logic          o_fifo_rden;
    logic          o_m_valid;
    logic [DW-1:0] o_m_data;
    logic          o_idle;
`ifdef FIFO_STREAM_XFER_CNT_EN
    logic [XFER_CNT_W-1:0] o_xfer_cnt;
`endif

    fifo_stream_out #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_rddata(i_fifo_rddata),
        .o_fifo_rden  (o_fifo_rden),
        .i_flush      (i_flush),
        .o_m_valid    (o_m_valid),
        .o_m_data     (o_m_data),
        .i_m_ready    (i_m_ready),
`ifdef FIFO_STREAM_XFER_CNT_EN
        .o_xfer_cnt   (o_xfer_cnt),
`endif
        .o_idle       (o_idle)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    int            n_take = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb_q[$];
    bit            pend_pop = 1'b0;
    bit            pend_clr = 1'b0;

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle: apply inputs at negedge, observe the pop decision.
    task automatic step(bit rn, bit rdy, bit fl);
        @(negedge clk);
        if (pend_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (pend_clr) sb_q.delete();
        rstn = rn;
        i_m_ready = rdy;
        i_flush = fl;
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_rddata = i_fifo_empty ? '0 : fifo_q[0];
        #1;
        pend_pop = o_fifo_rden;
        pend_clr = fl || !rn;
        if (o_fifo_rden) begin
            chk("rden_when_empty", int'(i_fifo_empty), 0);
            if (!i_fifo_empty) sb_q.push_back(fifo_q[0]);
        end
        if (fl) chk("rden_in_flush", int'(o_fifo_rden), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rstn) begin
                n_take = 0;
            end else if (o_m_valid && i_m_ready) begin
                n_take++;
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected none", o_m_data);
                end else begin
                    chk("sb_data", int'(o_m_data), int'(sb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pops;
        int pushed;
        int t0;

        fifo_q = {8'h11, 8'h22, 8'h33};
        step(0, 1, 0);
        step(0, 1, 0);
        chk("rst_valid", int'(o_m_valid), 0);
        chk("rst_data", int'(o_m_data), 0);
        chk("rst_idle", int'(o_idle), 1);
        chk("rst_rden", int'(o_fifo_rden), 0);

        step(1, 1, 0);
        chk("lat_c0_valid", int'(o_m_valid), 0);
        chk("lat_c0_rden", int'(o_fifo_rden), 1);
        step(1, 1, 0);
        chk("lat_c1_valid", int'(o_m_valid), 1);
        chk("lat_c1_data", int'(o_m_data), 'h11);
        step(1, 1, 0);
        chk("lat_c2_data", int'(o_m_data), 'h22);
        step(1, 1, 0);
        chk("lat_c3_data", int'(o_m_data), 'h33);
        step(1, 1, 0);
        chk("lat_idle", int'(o_idle), 1);

        fifo_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            pops += int'(o_fifo_rden);
            if (i > 0) chk("stall_data", int'(o_m_data), 'hA0);
        end
        chk("stall_pops", pops, 2);
        chk("stall_valid", int'(o_m_valid), 1);
        chk("stall_two_rden", int'(o_fifo_rden), 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 0);
            chk("burst_valid", int'(o_m_valid), 1);
            chk("burst_data", int'(o_m_data), 'hA0 + k);
        end
        step(1, 1, 0);
        chk("burst_idle", int'(o_idle), 1);

        fifo_q = {8'h55, 8'h66, 8'h77};
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("fl_pre_data", int'(o_m_data), 'h55);
        chk("fl_pre_rden", int'(o_fifo_rden), 0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("fl_valid", int'(o_m_valid), 0);
        chk("fl_next_rden", int'(o_fifo_rden), 1);
        step(1, 0, 0);
        chk("fl_next_valid", int'(o_m_valid), 1);
        chk("fl_next_data", int'(o_m_data), 'h77);
        step(1, 1, 0);
        step(1, 1, 0);
        chk("fl_idle", int'(o_idle), 1);

        fifo_q = {8'h01, 8'h02, 8'h03};
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        chk("mr_pre_data", int'(o_m_data), 'h01);
        fifo_q.delete();
        step(0, 0, 0);
        step(1, 0, 0);
        chk("mr_valid", int'(o_m_valid), 0);
        chk("mr_data", int'(o_m_data), 0);
        chk("mr_idle", int'(o_idle), 1);

        pushed = 0;
        t0 = n_take;
        while (pushed < 1000) begin
            if ($urandom_range(0, 9) < 6) begin
                fifo_q.push_back(DW'($urandom_range(0, 255)));
                pushed++;
            end
            step(1, 1'($urandom_range(0, 1)), 0);
        end
        for (int i = 0; i < 200 && (fifo_q.size() > 0 || sb_q.size() > 0 || o_m_valid); i++)
            step(1, 1, 0);
        chk("rand_left", fifo_q.size() + sb_q.size(), 0);
        chk("rand_takes", n_take - t0, 1000);

`ifdef FIFO_STREAM_XFER_CNT_EN
        step(0, 0, 0);
        step(0, 0, 0);
        chk("cnt_rst", int'(o_xfer_cnt), 0);
        pushed = 0;
        for (int i = 0; i < 70200; i++) begin
            if (pushed < 70000 && fifo_q.size() < 3) begin
                fifo_q.push_back(DW'(pushed));
                pushed++;
            end
            step(1, 1, 0);
            if (pushed == 70000 && fifo_q.size() == 0 && !o_m_valid) break;
        end
        chk("cnt_70000", int'(o_xfer_cnt), 4464);
        fifo_q.push_back(8'h5A);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk("cnt_flush_valid", int'(o_m_valid), 0);
        chk("cnt_after_flush", int'(o_xfer_cnt), 4464);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
- Read-side output stage placed directly downstream of the single-clock 2^N LUT-RAM FIFO.
- The FIFO is show-ahead: its read data is valid at the head whenever its empty flag is low, and a read-enable pops that word.
- This block pops the FIFO and presents the words as a registered valid/ready stream.
- It holds a 2-entry output/skid buffer, so o_fifo_rden never depends combinationally on i_m_ready and full throughput of 1 word/cycle is kept.

Parameters:
- DATA_W, 4, data width; must equal the FIFO data width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_rddata  in  DATA_W  FIFO head word; valid when i_fifo_empty=0.
- o_fifo_rden  out  1  FIFO pop.
- i_flush  in  1  synchronous discard of words held in this stage.
- o_m_valid  out  1  stream valid, registered.
- o_m_data  out  DATA_W  stream data, registered.
- i_m_ready  in  1  stream ready from the consumer.
- o_idle  out  1  high when the stage holds no word.

Behaviour:
- Reset is rstn, synchronous, active-low; clock is clk.
- During reset:
  - FSM=S_EMPTY, o_m_valid=0, o_m_data=0, skid register=0, o_idle=1.
  - o_fifo_rden=0 (gated by rstn).
- Internal storage: out_reg drives o_m_data; skid_reg is the second entry.
- FSM state is the registered word count: S_EMPTY(0), S_ONE(1), S_TWO(2). o_m_valid=(state!=S_EMPTY); o_idle=(state==S_EMPTY).
- Pop rule: o_fifo_rden = rstn & !i_fifo_empty & !i_flush & (state!=S_TWO).
  - Combinational from registered state and FIFO flags only.
  - No path from i_m_ready.
- Let pop=o_fifo_rden and take=o_m_valid & i_m_ready. Transitions:
  - S_EMPTY: pop -> out_reg<=rddata, S_ONE; else stay.
  - S_ONE, take & pop: out_reg<=rddata, stay S_ONE.
  - S_ONE, take & !pop: -> S_EMPTY.
  - S_ONE, !take & pop: skid_reg<=rddata, -> S_TWO.
  - S_ONE, !take & !pop: hold.
  - S_TWO, take: out_reg<=skid_reg, -> S_ONE.
  - S_TWO, !take: hold (no pop).
- Latency: a word at the FIFO head in cycle N with state S_EMPTY appears on o_m_valid/o_m_data in cycle N+1.
- Sustained throughput is 1 word/cycle while i_m_ready=1 and the FIFO is non-empty.
- Ordering is strict FIFO order; no word is duplicated or lost.
- o_m_data is stable while o_m_valid=1 and i_m_ready=0 (AXI-S style: valid is never retracted without take).
- Flush:
  - i_flush=1 -> next state S_EMPTY; held words are dropped; o_fifo_rden=0 that cycle.
  - take in the flush cycle is still a legal transfer of the current word.
  - The FIFO contents are untouched.
- Flush has priority over pop/take updates; reset has priority over flush.
- Reset mid-stream discards held words; the FIFO is reset by the same rstn.
- When i_fifo_empty=1, no pop occurs and the state only drains.

Optional Feature:
- Macro: FIFO_STREAM_XFER_CNT_EN.
- When defined:
  - Adds port o_xfer_cnt, out, XFER_CNT_W (package constant, 16).
  - The counter increments on each take and wraps modulo 2^16.
  - It resets to 0 on rstn and is not cleared by i_flush.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_stream_pkg:
  - typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} fs_state_t.
  - localparam XFER_CNT_W=16.
- No sub-module; a single module (approx. 150-200 lines).

Test Plan (DATA_W=8):
- Preload FIFO with 0x11,0x22,0x33, hold i_m_ready=1 -> o_m_valid from cycle 1 after rstn release; data 0x11,0x22,0x33 on consecutive cycles; then o_idle=1.
- i_m_ready=0 with FIFO holding 0xA0..0xA3 -> exactly 2 pops, state S_TWO, o_m_data=0xA0 held stable; on ready=1, 0xA0,0xA1,0xA2,0xA3 in order with no gaps.
- Random i_m_ready (50%), 1000 random words -> scoreboard exact order match; assert o_fifo_rden never high when i_fifo_empty=1.
- In S_TWO holding 0x55,0x66, assert i_flush one cycle -> next cycle o_m_valid=0 and o_fifo_rden=0 in the flush cycle; the next FIFO word 0x77 appears after.
- Assert rstn=0 mid-stream in S_TWO -> next cycle o_m_valid=0, o_m_data=0, o_idle=1.
- With FIFO_STREAM_XFER_CNT_EN, 70000 transfers -> o_xfer_cnt=70000 mod 65536=4464; unaffected by flush.
